serial_adder_8bit: RTL and testbench
====================================

SERIAL_ADDER_8BIT -- requirements
Module: serial_adder_8bit

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits; WIDTH >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: start  input  1  operation request, sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  addend A, captured on accepted start.
REQ-006 Port: b  input  WIDTH  addend B, captured on accepted start.
REQ-007 Port: cin  input  1  carry-in, captured on accepted start.
REQ-008 Port: busy  output  1  high while in RUN.
REQ-009 Port: done  output  1  one-cycle pulse, high only in DONE.
REQ-010 Port: sum  output  WIDTH  registered result of the last completed operation.
REQ-011 Port: cout  output  1  carry out of the MSB, last completed operation.
REQ-012 Port: ovf  output  1  two's-complement overflow, last completed operation.

Function
REQ-013 The block SHALL be a bit-serial adder, LSB first, one bit per clock, using a single carry flip-flop.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE with start=1 at an edge SHALL load a, b and cin into internal shift registers and the carry flop, clear the bit counter, and move to RUN.
REQ-016 IDLE with start=0 SHALL remain in IDLE.
REQ-017 Each RUN edge SHALL compute bit = A[0]^B[0]^c and the new carry = majority(A[0],B[0],c).
- The same edge SHALL shift bit into the MSB of the internal sum register and shift A and B right by one.
- The bit counter SHALL increment.
REQ-018 RUN SHALL last exactly WIDTH edges; the WIDTH-th RUN edge SHALL transfer the results to sum, cout and ovf and move to DONE.
REQ-019 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB; the carry into the MSB SHALL be held in a register across the final step.
REQ-020 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-021 Latency: with start sampled at edge N, done SHALL be high in the cycle after edge N+WIDTH; the earliest next start is sampled at edge N+WIDTH+2.
REQ-022 start SHALL be ignored in RUN and DONE; a and b changes after capture SHALL NOT affect the result in progress.
REQ-023 sum, cout and ovf SHALL change only on entry to DONE and SHALL hold their values until the next entry to DONE.
REQ-024 Result width: sum is (A+B+cin) mod 2^WIDTH and cout is bit WIDTH of that addition; no other width extension SHALL occur.
REQ-025 Subtraction usage: a, b=~x and cin=1 SHALL yield a-x, with cout=1 meaning no borrow.

Reset
REQ-026 Asserting rst SHALL immediately force IDLE, regardless of clk.
- busy=0, done=0, sum=0, cout=0, ovf=0.
- Shift registers, carry flop and bit counter cleared.
REQ-027 rst mid-RUN SHALL abort the operation with no done pulse; sum, cout and ovf SHALL read 0.
REQ-028 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-029 a=0x05, b=0x03, cin=0, 1-cycle start -> busy for 8 cycles, then done pulse; sum=0x08, cout=0, ovf=0.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
REQ-031 a=0x0A, b=0xFC, cin=1 (10-3) -> sum=0x07, cout=1; a=0x03, b=0xF5, cin=1 (3-10) -> sum=0xF9, cout=0.
REQ-032 Protected capture:
- Start a=0x10, b=0x20, then change a/b and pulse start during RUN -> single done, sum=0x30.
- Start held high continuously -> done pulses every 10 cycles.
REQ-033 rst asserted asynchronously on the 4th RUN cycle -> outputs immediately 0 and no done pulse; next start with a=0x01, b=0x01 -> sum=0x02 after 8 cycles.
REQ-034 Random a/b/cin, 1000 operations -> {cout,sum} equals a+b+cin and ovf matches the sign rule on every done pulse.

Source files
------------

// File: rtl/serial_adder_8bit.sv
// Bit-serial ripple adder: LSB first, one bit per clock through a single carry flop.
// Results are registered on the last step and held until the next operation completes.
//
// state | meaning
// IDLE  | waiting for start; operands loaded on accepted start
// RUN   | one sum bit per edge, WIDTH edges
// DONE  | one-cycle done pulse, then back to IDLE
module serial_adder_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s, carry_nxt, last_step;

  assign bit_s     = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last_step = (state == RUN) && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // On the final step the carry flop still holds the carry into the MSB,
  // so ovf is formed from it and the freshly computed carry out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= cin;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= {bit_s, sum_sh[WIDTH-1:1]};
          carry  <= carry_nxt;
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            sum  <= {bit_s, sum_sh[WIDTH-1:1]};
            cout <= carry_nxt;
            ovf  <= carry ^ carry_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_8bit.sv
// Scoreboard bench for serial_adder_8bit: the driver pushes expected results,
// a monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_serial_adder_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int ops_issued = 0;
  int cyc = 0;
  logic [9:0] exp_q[$];

  serial_adder_8bit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {cout, ovf, sum}: ovf when both addends share a sign the sum lacks.
  function automatic logic [9:0] model(input logic [7:0] ta, input logic [7:0] tb2, input logic tc);
    logic [8:0] full;
    logic       v;
    full = {1'b0, ta} + {1'b0, tb2} + {8'd0, tc};
    v    = (ta[7] == tb2[7]) && (full[7] != ta[7]);
    return {full[8], v, full[7:0]};
  endfunction

  always @(negedge clk) begin
    if (done) begin
      logic [9:0] e;
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum",  {24'd0, sum}, {24'd0, e[7:0]});
        check("cout", {31'd0, cout}, {31'd0, e[9]});
        check("ovf",  {31'd0, ovf},  {31'd0, e[8]});
      end
    end
  end

  // Called at a negedge in IDLE; returns at the negedge of the following idle cycle.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb2, input logic tc,
                        input bit disturb);
    int busy_cnt;
    a = ta; b = tb2; cin = tc; start = 1'b1;
    exp_q.push_back(model(ta, tb2, tc));
    ops_issued++;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (disturb) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); start = 1'b1;
      end
    end
    check("busy_cycles", busy_cnt, 8);
    @(negedge clk);
    start = 1'b0;
    check("done_latency", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("done_clear", {30'd0, done, busy}, 32'd0);
  endtask

  task automatic wait_done(output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t0, t1, t2;
    #1;
    check("reset_outputs", {21'd0, busy, done, sum, cout, ovf}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h05, 8'h03, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(8'h0A, 8'hFC, 1'b1, 1'b0);
    run_op(8'h03, 8'hF5, 1'b1, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 1'b0);
    run_op(8'h10, 8'h20, 1'b0, 1'b1);

    // start held high: back-to-back operations every WIDTH+2 cycles
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(8'h11, 8'h22, 1'b0));
      ops_issued++;
    end
    wait_done(t0);
    wait_done(t1);
    wait_done(t2);
    start = 1'b0;
    check("held_period_1", t1 - t0, 10);
    check("held_period_2", t2 - t1, 10);
    @(negedge clk);

    // asynchronous reset during the 4th RUN cycle aborts without a done pulse
    a = 8'h55; b = 8'h11; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_outputs", {21'd0, busy, done, sum, cout, ovf}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_op(8'h01, 8'h01, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("done_count", done_seen, ops_issued);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
